// File: rtl/operand_reader.sv
// operand_reader: operand-read stage between decode and execute.
// Accepts decoded register specifiers over valid/ready. Reads both sources
// from the flat register-file output, bypassing a writeback that lands in
// the same cycle. A busy scoreboard stalls RAW and WAW hazards against
// in-flight writebacks. Results go to execute through a one-entry
// registered valid/ready stage.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        decode handshake (in_ready does not depend on in_valid)
//   in_rs1, in_rs2           source indices
//   in_rd, in_rd_wen         destination index / write enable
//   rf_data                  register file contents, one word per register
//   wb_wen/waddr/wdata       writeback bus snooped from the register file
//   flush                    squash output stage and scoreboard
//   out_valid/out_ready      execute handshake
//   out_op1, out_op2         operand values
//   out_rd, out_rd_wen       forwarded destination
module operand_reader #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1,
   input  logic [AW-1:0]   in_rs2,
   input  logic [AW-1:0]   in_rd,
   input  logic            in_rd_wen,
   input  logic [XLEN-1:0] rf_data [NREG-1:0],
   input  logic            wb_wen,
   input  logic [AW-1:0]   wb_waddr,
   input  logic [XLEN-1:0] wb_wdata,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_op1,
   output logic [XLEN-1:0] out_op2,
   output logic [AW-1:0]   out_rd,
   output logic            out_rd_wen
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic            w_byp1, w_byp2, w_bypd;
   logic            w_stall1, w_stall2, w_stalld;
   logic            w_hazard;
   logic            w_accept;
   logic            w_sets_rd;
   logic [XLEN-1:0] w_op1, w_op2;

   // Same-cycle writeback match per specifier; x0 never matches usefully
   // because the x0 checks below take precedence.
   assign w_byp1 = wb_wen && (wb_waddr == in_rs1);
   assign w_byp2 = wb_wen && (wb_waddr == in_rs2);
   assign w_bypd = wb_wen && (wb_waddr == in_rd);

   // Operand select: x0 reads zero, then bypass, then register file.
   assign w_op1 = (in_rs1 == '0) ? '0 : (w_byp1 ? wb_wdata : rf_data[in_rs1]);
   assign w_op2 = (in_rs2 == '0) ? '0 : (w_byp2 ? wb_wdata : rf_data[in_rs2]);

   // Hazards: a pending writeback blocks unless it lands this very cycle.
   assign w_stall1  = (in_rs1 != '0) && r_busy[in_rs1] && !w_byp1;
   assign w_stall2  = (in_rs2 != '0) && r_busy[in_rs2] && !w_byp2;
   assign w_stalld  = in_rd_wen && (in_rd != '0) && r_busy[in_rd] && !w_bypd;
   assign w_hazard  = w_stall1 || w_stall2 || w_stalld;

   assign in_ready  = !flush && !w_hazard && (!out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_sets_rd = w_accept && in_rd_wen && (in_rd != '0);

   // Scoreboard next state: clear on writeback first so a same-cycle set wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (wb_wen && (wb_waddr != '0)) begin
         w_busy_nxt[wb_waddr] = 1'b0;
      end
      if (w_sets_rd) begin
         w_busy_nxt[in_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Scoreboard register; flush discards every pending entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else if (flush) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // One-entry output stage; data holds while stalled and across flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_op1    <= '0;
         out_op2    <= '0;
         out_rd     <= '0;
         out_rd_wen <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
      end else if (w_accept) begin
         out_valid  <= 1'b1;
         out_op1    <= w_op1;
         out_op2    <= w_op2;
         out_rd     <= in_rd;
         out_rd_wen <= in_rd_wen;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: doc/operand_reader.md
# operand_reader

Operand-read stage on the read side of the integer register file. It accepts decoded register specifiers over a valid/ready handshake and reads both source operands from the register file's flat data output. A per-register busy scoreboard blocks reads of registers whose writeback is still in flight. A writeback that lands in the same cycle is bypassed. Operands go to execute through a one-entry registered valid/ready output. It sits between decode and execute and snoops the same `wen`/`waddr`/`wdata` bus that drives the register file.

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, number of architectural registers; address width `AW = $clog2(NREG)`
- `clk` input 1, single clock, all state on rising edge
- `rst` input 1, reset, asynchronous, active-high
- `in_valid` input 1, decoded instruction present
- `in_ready` output 1, instruction accepted this cycle when `in_valid && in_ready`
- `in_rs1`, `in_rs2` input AW, source register indices
- `in_rd` input AW, destination index
- `in_rd_wen` input 1, instruction will write `in_rd`
- `rf_data` input XLEN×NREG (unpacked `[NREG-1:0]`), current register file contents
- `wb_wen` input 1, writeback this cycle (same signal as register file `wen`)
- `wb_waddr` input AW, writeback index
- `wb_wdata` input XLEN, writeback data
- `flush` input 1, squash the output register and the scoreboard
- `out_valid` output 1, operands valid
- `out_ready` input 1, execute consumes when `out_valid && out_ready`
- `out_op1`, `out_op2` output XLEN, operand values
- `out_rd` output AW, `out_rd_wen` output 1, forwarded destination

## Operation
- Scoreboard: `busy[NREG]`. `busy[0]` is constant 0.
- Source read, for N in {1,2}, when `in_rsN == 0`: operand = 0 regardless of `rf_data[0]`.
- Source read, else if `wb_wen && wb_waddr == in_rsN`: operand = `wb_wdata` (bypass).
- Source read, else: operand = `rf_data[in_rsN]`.
- Source stall: `in_rsN != 0 && busy[in_rsN] && !(wb_wen && wb_waddr == in_rsN)`.
- Destination stall (WAW): `in_rd_wen && in_rd != 0 && busy[in_rd] && !(wb_wen && wb_waddr == in_rd)`.
- `hazard` = any stall term.
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`. It is combinational from the `in_*` fields, the `wb_*` signals, `out_ready` and `flush`, but does not depend on `in_valid`.
- Accept loads `out_op1`, `out_op2`, `out_rd`, `out_rd_wen` and sets `out_valid = 1`.
- Accept also sets `busy[in_rd]` if `in_rd_wen && in_rd != 0`.
- Output drains when `out_valid && out_ready` with no accept that cycle; then `out_valid` goes to 0.
- Writeback clears `busy[wb_waddr]` when `wb_wen && wb_waddr != 0`.
- If an accept sets the same bit that a writeback clears in the same cycle, set wins.
- `wb_wen` with `wb_waddr == 0` has no effect.
- Flush has priority over everything: `out_valid` goes to 0 and all `busy` bits clear, including any set or clear that cycle. Data outputs keep their values.
- Output data is stable while `out_valid && !out_ready`.

## Timing
- Reset state: `out_valid`, `out_op1`, `out_op2`, `out_rd`, `out_rd_wen` all 0; `busy` all 0. `in_ready` is then 1 unless `flush` is asserted.
- Reset asserted mid-operation clears state immediately, independent of `clk`.
- Latency: accept at edge T gives `out_valid = 1` after T. Full throughput is one instruction per cycle with `out_ready` held at 1.
- Back-to-back dependency, where instruction B reads the `rd` of A: B stalls until the cycle in which `wb_wen` for that `rd` is high. B is accepted in that same cycle with the bypassed value, so there is zero extra cycles after writeback.
- A register file write at edge T becomes visible through `rf_data` after T. The bypass covers the cycle before that edge.

## Test plan
- Reset, then accept `rs1=3, rs2=0, rd=5, rd_wen=1` with `rf_data[3]=0x1234`. Required next cycle: `out_valid=1, out_op1=0x1234, out_op2=0, out_rd=5`, and `busy[5]=1`.
- With `busy[5]=1`, present `rs1=5` and no writeback. Required: `in_ready=0` every cycle. Then drive `wb_wen=1, wb_waddr=5, wb_wdata=0xDEAD`. Required: `in_ready=1` that cycle, `out_op1=0xDEAD` after the edge, and `busy[5]=0`.
- WAW with `busy[7]=1`: present `rd=7, rd_wen=1`. Required: stall. Next, drive writeback to 7 in the same cycle. Required: accept, and `busy[7]` stays 1.
- Backpressure: hold `out_ready=0` with `out_valid=1`. Required: `in_ready=0` and output fields unchanged for 4 cycles. Then `out_ready=1` with a new valid input. Required: a new value loads the following cycle with no bubble.
- Register x0: `rs1=0, rs2=0` with `rf_data[0]=0xFFFFFFFF`, and `rd=0, rd_wen=1`. Required: both operands 0 and no busy bit set. Also, `wb_waddr=0` must not unblock a stall on `rs1=0`; the stall never occurs.
- Flush with `busy[2]`, `busy[9]` set and `out_valid=1`. Required next cycle: `out_valid=0` and all busy bits 0. Also, assert `rst` mid-stall: outputs are 0 immediately, without waiting for `clk`.
